// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O window on the data-memory port: LED data/blink, debounced switches,
// sticky IR edge capture with IRQ. LED_DATA holds N_LED bits; all window reads are zero-extended.
module mmio_io_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int BASE_ADDR    = 28,
  parameter int N_SW         = 5,
  parameter int N_LED        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int BLINK_DIV    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata_out,
  input  logic [N_SW-1:0]   sw_in,
  input  logic              ir_in,
  output logic [N_LED-1:0]  led_out,
  output logic              irq
);

  localparam int CNT_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PRE_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(BLINK_DIV - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);

  if (ADDR_W < 2 || DATA_W < 3 || BASE_ADDR + 3 > 2**ADDR_W - 1 || N_SW > DATA_W ||
      N_LED > DATA_W || SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || BLINK_DIV < 1) begin : g_param_err
    $error("mmio_io_ctrl: illegal parameter combination");
  end

  logic [ADDR_W-1:0] rel;
  logic [1:0]        off;
  logic              hit, wr_led, wr_ctrl, wr_ir;

  assign rel     = mem_addr - BASE_A;
  assign off     = rel[1:0];
  assign hit     = (mem_addr >= BASE_A) && (mem_addr <= BASE_A + ADDR_W'(3));
  assign wr_led  = mem_we && hit && (off == 2'd0);
  assign wr_ctrl = mem_we && hit && (off == 2'd1);
  assign wr_ir   = mem_we && hit && (off == 2'd3);

  logic [N_SW-1:0]        sw_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ir_sync;
  logic [N_SW-1:0]        sw_s;
  logic                   ir_s;

  assign sw_s = sw_sync[SYNC_STAGES-1];
  assign ir_s = ir_sync[SYNC_STAGES-1];

  logic [N_LED-1:0]  led_data;
  logic              blink_en, irq_en, ir_pend, ir_armed, phase;
  logic [N_SW-1:0]   stable;
  logic [CNT_W-1:0]  cnt [N_SW];
  logic [PRE_W-1:0]  presc;
  logic [FILL_W-1:0] fill;
  logic              ir_edge;

  // Reset zeros in the synchroniser are not samples, so an edge needs a real synced 0 first.
  assign ir_edge = ir_s && ir_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
      ir_sync  <= '0;
      fill     <= '0;
      ir_armed <= 1'b0;
    end else begin
      sw_sync[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
      ir_sync  <= {ir_sync[SYNC_STAGES-2:0], ir_in};
      if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
      ir_armed <= (fill == FILL_FULL) && !ir_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int b = 0; b < N_SW; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < N_SW; b++) begin
        if (sw_s[b] == stable[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          stable[b] <= sw_s[b];
          cnt[b]    <= '0;
        end else begin
          cnt[b] <= cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_data <= '0;
      blink_en <= 1'b0;
      irq_en   <= 1'b0;
      ir_pend  <= 1'b0;
      presc    <= '0;
      phase    <= 1'b1;
    end else begin
      if (wr_led) led_data <= mem_wdata[N_LED-1:0];
      if (wr_ctrl) blink_en <= mem_wdata[0];
      if (wr_ir) irq_en <= mem_wdata[2];
      // Set beats W1C when both land on the same edge.
      ir_pend <= ir_edge || (ir_pend && !(wr_ir && mem_wdata[0]));
      if (wr_ctrl) begin
        presc <= '0;
        phase <= 1'b1;
      end else if (presc == PRE_LAST) begin
        presc <= '0;
        phase <= !phase;
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

  assign led_out = blink_en ? (led_data & {N_LED{phase}}) : led_data;
  assign irq     = ir_pend && irq_en;

  always_comb begin
    rdata_out = ram_rdata;
    if (hit) begin
      rdata_out = '0;
      case (off)
        2'd0:    rdata_out[N_LED-1:0] = led_data;
        2'd1:    rdata_out[0]         = blink_en;
        2'd2:    rdata_out[N_SW-1:0]  = stable;
        default: rdata_out[2:0]       = {irq_en, ir_s, ir_pend};
      endcase
    end
  end

  logic unused_sink;
  assign unused_sink = ^{mem_wdata, rel};

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed scenarios then randomized traffic, checked each cycle
// against a queue-based behavioural model through a scoreboard.
module tb_mmio_io_ctrl;
  localparam int DW = 32, AW = 5, BASE = 28, NSW = 5, NLED = 4, SS = 2, DB = 4, BD = 8;

  logic            clk = 1'b0;
  logic            reset, mem_we, ir_in, irq;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, ram_rdata, rdata_out;
  logic [NSW-1:0]  sw_in;
  logic [NLED-1:0] led_out;

  mmio_io_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .N_SW(NSW), .N_LED(NLED),
                 .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_rdata(ram_rdata), .rdata_out(rdata_out), .sw_in(sw_in), .ir_in(ir_in),
    .led_out(led_out), .irq(irq));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   rdata;
    logic [NLED-1:0] led;
    logic            irq;
    string           tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  string cur_tag = "init";
  logic [NSW-1:0] cur_sw;
  logic           cur_ir;

  // Reference model state
  logic [NLED-1:0] m_led;
  logic            m_blink, m_irqen, m_pend, m_armed;
  logic [NSW-1:0]  m_stable;
  int              m_since;
  logic [NSW-1:0]  m_swq[$];
  logic            m_irq_q[$];
  logic            m_realq[$];
  logic [NSW-1:0]  m_hist[$];

  function automatic void model_reset();
    m_led = '0; m_blink = 1'b0; m_irqen = 1'b0; m_pend = 1'b0; m_armed = 1'b0;
    m_stable = '0; m_since = 0;
    m_swq = {}; m_irq_q = {}; m_realq = {}; m_hist = {};
    for (int i = 0; i < SS; i++) begin
      m_swq.push_back('0); m_irq_q.push_back(1'b0); m_realq.push_back(1'b0);
    end
    for (int i = 0; i < DB; i++) m_hist.push_back('0);
  endfunction

  function automatic exp_t model_out(input logic [AW-1:0] a, input logic [DW-1:0] rr);
    exp_t e;
    int   off;
    logic ph;
    ph = ((m_since / BD) % 2) == 0;
    e.led = m_blink ? (m_led & {NLED{ph}}) : m_led;
    e.irq = m_pend & m_irqen;
    e.tag = cur_tag;
    if (int'(a) >= BASE && int'(a) <= BASE + 3) begin
      off = int'(a) - BASE;
      e.rdata = '0;
      case (off)
        0:       e.rdata[NLED-1:0] = m_led;
        1:       e.rdata[0] = m_blink;
        2:       e.rdata[NSW-1:0] = m_stable;
        default: e.rdata[2:0] = {m_irqen, m_irq_q[SS-1], m_pend};
      endcase
    end else begin
      e.rdata = rr;
    end
    return e;
  endfunction

  function automatic void model_tick(input logic rst, input logic we, input logic [AW-1:0] a,
                                     input logic [DW-1:0] wd, input logic [NSW-1:0] sw,
                                     input logic ir);
    logic [NSW-1:0] s_sw;
    logic s_ir, s_real, hitw, all_diff;
    int off;
    if (rst) begin
      model_reset();
      return;
    end
    s_sw   = m_swq[SS-1];
    s_ir   = m_irq_q[SS-1];
    s_real = m_realq[SS-1];
    hitw   = we && int'(a) >= BASE && int'(a) <= BASE + 3;
    off    = int'(a) - BASE;
    if (hitw && off == 0) m_led = wd[NLED-1:0];
    if (hitw && off == 1) begin
      m_blink = wd[0];
      m_since = 0;
    end else begin
      m_since++;
    end
    if (s_ir && m_armed) m_pend = 1'b1;
    else if (hitw && off == 3 && wd[0]) m_pend = 1'b0;
    if (hitw && off == 3) m_irqen = wd[2];
    m_armed = s_real && !s_ir;
    // A bit is accepted once the last DB synced samples all disagree with it.
    m_hist.push_front(s_sw);
    void'(m_hist.pop_back());
    for (int b = 0; b < NSW; b++) begin
      all_diff = 1'b1;
      foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    m_swq.push_front(sw);   void'(m_swq.pop_back());
    m_irq_q.push_front(ir); void'(m_irq_q.pop_back());
    m_realq.push_front(1'b1); void'(m_realq.pop_back());
  endfunction

  task automatic step(input logic rst, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [NSW-1:0] sw, input logic ir);
    reset = rst; mem_we = we; mem_addr = a; mem_wdata = wd; sw_in = sw; ir_in = ir;
    ram_rdata = $urandom();
    exp_q.push_back(model_out(a, ram_rdata));
    @(posedge clk);
    model_tick(rst, we, a, wd, sw, ir);
    #1;
  endtask

  task automatic rd(input int a);
    step(1'b0, 1'b0, AW'(a), $urandom(), cur_sw, cur_ir);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, AW'(a), d, cur_sw, cur_ir);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (rdata_out !== e.rdata) begin
          n_bad++;
          $display("FAIL %s rdata_out: got %h expected %h at %0t", e.tag, rdata_out, e.rdata, $time);
        end
        n_cmp++;
        if (led_out !== e.led) begin
          n_bad++;
          $display("FAIL %s led_out: got %h expected %h at %0t", e.tag, led_out, e.led, $time);
        end
        n_cmp++;
        if (irq !== e.irq) begin
          n_bad++;
          $display("FAIL %s irq: got %b expected %b at %0t", e.tag, irq, e.irq, $time);
        end
      end
    end
  end

  initial begin : main
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          we, rst;
    reset = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    sw_in = '0; ir_in = 1'b0; cur_sw = '0; cur_ir = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    cur_tag = "reset";
    step(1'b1, 1'b0, '0, '0, cur_sw, cur_ir);

    cur_tag = "reset_reads";
    for (int i = 0; i < 4; i++) rd(BASE + i);
    rd(0);

    cur_tag = "led_store";
    wr(BASE, 32'hA); rd(BASE);
    wr(BASE, 32'hFFFF_FFF5); rd(BASE); rd(5);

    cur_tag = "sw_debounce";
    cur_sw = 5'h13;
    repeat (10) rd(BASE + 2);
    cur_tag = "sw_glitch";
    cur_sw = 5'h12;
    repeat (3) rd(BASE + 2);
    cur_sw = 5'h13;
    repeat (10) rd(BASE + 2);

    cur_tag = "ir_edge";
    wr(BASE + 3, 32'h4);
    cur_ir = 1'b1;
    repeat (6) rd(BASE + 3);
    cur_ir = 1'b0;
    repeat (SS + 2) rd(BASE + 3);
    cur_tag = "ir_w1c_vs_edge";
    cur_ir = 1'b1;
    repeat (SS) rd(BASE + 3);
    wr(BASE + 3, 32'h5);
    repeat (2) rd(BASE + 3);
    cur_tag = "ir_w1c";
    wr(BASE + 3, 32'h5);
    repeat (3) rd(BASE + 3);

    cur_tag = "blink";
    cur_ir = 1'b0;
    wr(BASE, 32'hF);
    wr(BASE + 1, 32'h1);
    repeat (34) rd(BASE + 1);
    cur_tag = "blink_off";
    wr(BASE + 1, 32'h0);
    repeat (10) rd(BASE);

    cur_tag = "reset_mid";
    wr(BASE + 1, 32'h1);
    repeat (5) rd(BASE);
    cur_sw = 5'h0A;
    repeat (SS + 2) rd(BASE + 2);
    step(1'b1, 1'b0, AW'(BASE + 2), '0, cur_sw, cur_ir);
    repeat (12) rd(BASE + 2);

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) cur_sw = cur_sw ^ (NSW'(1) << $urandom_range(0, NSW - 1));
      if ($urandom_range(0, 4) == 0) cur_ir = ~cur_ir;
      a   = ($urandom_range(0, 9) < 7) ? AW'(BASE + $urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wd  = ($urandom_range(0, 1) == 1) ? $urandom() : DW'($urandom_range(0, 15));
      we  = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 399) == 0);
      step(rst, we, a, wd, cur_sw, cur_ir);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
